// File: rtl/memory_1r1w_pipe.sv
// Byte-masked 1-read/1-write memory with 1- or 2-cycle registered read and selectable collision mode.
// Optional post-reset zero-fill sequencer compiled in with `define MEMORY_1R1W_PIPE_CLEAR_EN.
module memory_1r1w_pipe #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 5,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_FIRST  = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ren,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic                    rvalid,
  output logic [DATA_WIDTH-1:0]   rdata,
  input  logic                    wen,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wmask,
  output logic                    busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int LANES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] lane_bits;
  logic [DATA_WIDTH-1:0] read_old;
  logic [DATA_WIDTH-1:0] read_word;
  logic                  rd_fire;
  logic                  wr_fire;
  logic                  s1_valid_reg;
  logic [DATA_WIDTH-1:0] s1_data_reg;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_bits[8*gi +: 8] = {8{wmask[gi]}};
    end
  endgenerate

`ifdef MEMORY_1R1W_PIPE_CLEAR_EN
  logic                  clear_active_reg;
  logic [ADDR_WIDTH-1:0] clear_addr_reg;
  logic                  clear_fire;

  // Reset parks the sweep at address 0; it runs once reset is released.
  always_ff @(posedge clock) begin
    if (reset) begin
      clear_active_reg <= 1'b1;
      clear_addr_reg   <= '0;
    end else if (clear_active_reg) begin
      clear_addr_reg <= clear_addr_reg + 1'b1;
      if (clear_addr_reg == '1) begin
        clear_active_reg <= 1'b0;
      end
    end
  end

  assign busy       = reset | clear_active_reg;
  assign clear_fire = clear_active_reg & ~reset;
`else
  assign busy = 1'b0;
`endif

  assign rd_fire  = ren & ~busy & ~reset;
  assign wr_fire  = wen & ~busy & ~reset;
  assign read_old = mem[raddr];

  generate
    if (WRITE_FIRST != 0) begin : g_write_first
      logic collide;
      assign collide   = wr_fire && (waddr == raddr);
      assign read_word = collide ? ((wdata & lane_bits) | (read_old & ~lane_bits)) : read_old;
    end else begin : g_read_first
      assign read_word = read_old;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (wr_fire) begin
      for (int b = 0; b < LANES; b++) begin
        if (wmask[b]) begin
          mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
`ifdef MEMORY_1R1W_PIPE_CLEAR_EN
    else if (clear_fire) begin
      mem[clear_addr_reg] <= '0;
    end
`endif
  end

  // Data registers only load on a delivered read so rdata holds between results.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
    end else begin
      s1_valid_reg <= rd_fire;
      if (rd_fire) begin
        s1_data_reg <= read_word;
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s2_valid_reg;
      logic [DATA_WIDTH-1:0] s2_data_reg;

      always_ff @(posedge clock) begin
        if (reset) begin
          s2_valid_reg <= 1'b0;
          s2_data_reg  <= '0;
        end else begin
          s2_valid_reg <= s1_valid_reg;
          if (s1_valid_reg) begin
            s2_data_reg <= s1_data_reg;
          end
        end
      end

      assign rvalid = s2_valid_reg;
      assign rdata  = s2_data_reg;
    end else begin : g_lat1
      assign rvalid = s1_valid_reg;
      assign rdata  = s1_data_reg;
    end
  endgenerate

endmodule

// File: doc/memory_1r1w_pipe.md
MEMORY_1R1W_PIPE -- requirements
Module: memory_1r1w_pipe

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, the word width in bits, which SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, the address width; depth is 2**ADDR_WIDTH words.
REQ-003 The block SHALL have parameter READ_LATENCY, default 1, legal values 1 or 2, the number of cycles from read request to data.
REQ-004 The block SHALL have parameter WRITE_FIRST, default 0: 0 selects read-first, 1 selects write-first on same-address collision.
REQ-005 Port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1: reset, synchronous and active-high.
REQ-007 Port ren, input, 1: read request.
REQ-008 Port raddr, input, ADDR_WIDTH: read address.
REQ-009 Port rvalid, output, 1: rdata carries the result of an accepted read.
REQ-010 Port rdata, output, DATA_WIDTH: read data.
REQ-011 Port wen, input, 1: write request.
REQ-012 Port waddr, input, ADDR_WIDTH: write address.
REQ-013 Port wdata, input, DATA_WIDTH: write data.
REQ-014 Port wmask, input, DATA_WIDTH/8: byte-lane write enables, bit i covers wdata[8i+7:8i].
REQ-015 Port busy, output, 1: block is not accepting requests.

Function
REQ-016 A write SHALL be accepted at a rising edge when wen=1 and busy=0, updating only the byte lanes with wmask bit set; wmask=0 SHALL leave memory unchanged.
REQ-017 A read SHALL be accepted at a rising edge when ren=1 and busy=0; rvalid SHALL be 1 for exactly one cycle, READ_LATENCY cycles after acceptance, with rdata holding the addressed word.
REQ-018 Back-to-back reads SHALL be accepted every cycle; throughput is one read per cycle at either latency.
REQ-019 rdata SHALL hold its last value when rvalid=0.
REQ-020 Same-edge read and write to the same address with WRITE_FIRST=0 SHALL return the pre-write word.
REQ-021 Same-edge read and write to the same address with WRITE_FIRST=1 SHALL return the merged word: masked lanes from wdata, unmasked lanes from the pre-write word.
REQ-022 Same-edge read and write to different addresses SHALL not interact.
REQ-023 A read accepted at the edge after a write to the same address SHALL return the written data in both modes.
REQ-024 Requests presented while busy=1 SHALL be dropped with no memory change and no rvalid.

Reset
REQ-025 While reset=1, rvalid SHALL be 0 and rdata SHALL be 0 at the following edge.
REQ-026 Reset SHALL flush all in-flight reads; no rvalid SHALL appear for reads accepted before reset.
REQ-027 Memory contents SHALL not be altered by reset except as given in REQ-029.

Configuration
REQ-028 Macro MEMORY_1R1W_PIPE_CLEAR_EN SHALL compile in a post-reset clear sequencer.
REQ-029 With MEMORY_1R1W_PIPE_CLEAR_EN defined, busy SHALL be 1 while reset=1 and for 2**ADDR_WIDTH cycles after reset deasserts, writing zero to addresses 0 through 2**ADDR_WIDTH-1 in ascending order, one per cycle; busy then falls to 0.
REQ-030 With MEMORY_1R1W_PIPE_CLEAR_EN defined, reset asserted mid-clear SHALL restart the clear from address 0.
REQ-031 Without MEMORY_1R1W_PIPE_CLEAR_EN, busy SHALL be constant 0, requests are accepted the first edge after reset deasserts, and contents after power-up are undefined.

Verification
REQ-032 Defaults: write 0x0123456789ABCDEF to address 3, read address 3 next cycle -> rvalid=1 one cycle later, rdata=0x0123456789ABCDEF.
REQ-033 WRITE_FIRST=0 vs 1: address 7 holds 0x1111111111111111; same edge write 0xFFFFFFFFFFFFFFFF with wmask=0x0F and read address 7 -> rdata 0x1111111111111111 (mode 0) or 0x11111111FFFFFFFF (mode 1).
REQ-034 READ_LATENCY=2: reads of addresses 0,1,2 on consecutive edges -> rvalid high on three consecutive cycles starting two cycles after the first, data in order.
REQ-035 Reset asserted one cycle after a read is accepted with READ_LATENCY=2 -> no rvalid appears, rdata=0.
REQ-036 With MEMORY_1R1W_PIPE_CLEAR_EN: write 0xAA to address 31, pulse reset -> busy high for exactly 32 cycles after deassertion, write during busy ignored, then read address 31 returns 0.
REQ-037 Without MEMORY_1R1W_PIPE_CLEAR_EN: busy never rises; read with ren=1 on first post-reset edge yields rvalid READ_LATENCY cycles later.
